// File: rtl/ppu_pkg.sv
// ppu_pkg: shared constants, slot indices and scheduler state encoding.
package ppu_pkg;
    localparam int          V_ACTIVE     = 480;
    localparam logic [13:0] EMPTY_ENTITY = 14'h3C00;
    localparam logic [17:0] EMPTY_ARRAY  = 18'h3C000;
    localparam logic [3:0]  SLOT_MIN     = 4'd1;
    localparam logic [3:0]  SLOT_ARRAY   = 4'd7;
    localparam logic [3:0]  SLOT_MAX     = 4'd9;

    typedef enum logic [1:0] {DISPLAY, COMMIT, BLANK, DEFER} state_t;

    // Maps the 14-bit slots 1..6, 8, 9 onto a dense 0..7 storage index.
    function automatic logic [2:0] slot_idx(input logic [3:0] slot);
        return 3'(slot > SLOT_ARRAY ? slot - 4'd2 : slot - 4'd1);
    endfunction
endpackage

// File: rtl/vblank_edge_detect.sv
// vblank_edge_detect: derives vblank from the scan line and flags its rising edge.
module vblank_edge_detect #(
    parameter int V_ACTIVE = 480
) (
    input  logic       pixel_clk,
    input  logic       reset_n,
    input  logic [9:0] y_pos,
    output logic       vblank,
    output logic       vblank_rise
);
    localparam logic [9:0] V_LINE = 10'(V_ACTIVE);

    logic vblank_prev;

    assign vblank      = y_pos >= V_LINE;
    assign vblank_rise = vblank && !vblank_prev;

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) vblank_prev <= 1'b0;
        else          vblank_prev <= vblank;
    end
endmodule

// File: rtl/entity_update_scheduler.sv
// entity_update_scheduler: double-buffers entity slot writes and swaps the
// whole set into the active registers once per vblank, unless frame_lock defers it.
module entity_update_scheduler #(
    parameter int          V_ACTIVE     = ppu_pkg::V_ACTIVE,
    parameter logic [13:0] EMPTY_ENTITY = ppu_pkg::EMPTY_ENTITY,
    parameter logic [17:0] EMPTY_ARRAY  = ppu_pkg::EMPTY_ARRAY
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    input  logic [9:0]  y_pos,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_slot,
    input  logic [17:0] wr_data,
    input  logic        frame_lock,
    output logic [13:0] entity_1,
    output logic [13:0] entity_2,
    output logic [13:0] entity_3,
    output logic [13:0] entity_4,
    output logic [13:0] entity_5,
    output logic [13:0] entity_6,
    output logic [17:0] entity_7,
    output logic [13:0] entity_8_flip,
    output logic [13:0] entity_9_flip,
    output logic        commit_pulse,
    output logic        even_frame,
    output logic [7:0]  skip_count,
    output logic        slot_err
);
    import ppu_pkg::*;

    state_t      state, state_next;
    logic        vblank, vblank_rise, accept, slot_ok, skip_inc;
    logic [13:0] shadow [8];
    logic [13:0] active [8];
    logic [17:0] shadow_arr, active_arr;

    vblank_edge_detect #(.V_ACTIVE(V_ACTIVE)) u_edge (
        .pixel_clk  (pixel_clk),
        .reset_n    (reset_n),
        .y_pos      (y_pos),
        .vblank     (vblank),
        .vblank_rise(vblank_rise)
    );

    assign wr_ready     = reset_n && state != COMMIT;
    assign commit_pulse = state == COMMIT;
    assign accept       = wr_valid && wr_ready;
    assign slot_ok      = wr_slot >= SLOT_MIN && wr_slot <= SLOT_MAX;

    always_comb begin
        state_next = state;
        skip_inc   = 1'b0;
        case (state)
            DISPLAY: if (vblank_rise) state_next = frame_lock ? DEFER : COMMIT;
            COMMIT:  state_next = BLANK;
            BLANK:   if (!vblank) state_next = DISPLAY;
            DEFER: begin
                // The end of vblank wins over a simultaneous lock release.
                if (!vblank) begin
                    state_next = DISPLAY;
                    skip_inc   = 1'b1;
                end else if (!frame_lock) begin
                    state_next = COMMIT;
                end
            end
        endcase
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) state <= DISPLAY;
        else          state <= state_next;
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= EMPTY_ENTITY;
                active[i] <= EMPTY_ENTITY;
            end
            shadow_arr <= EMPTY_ARRAY;
            active_arr <= EMPTY_ARRAY;
            even_frame <= 1'b0;
            skip_count <= 8'd0;
            slot_err   <= 1'b0;
        end else begin
            if (accept && slot_ok) begin
                if (wr_slot == SLOT_ARRAY) shadow_arr <= wr_data;
                else                       shadow[slot_idx(wr_slot)] <= wr_data[13:0];
            end
            if (commit_pulse) begin
                active     <= shadow;
                active_arr <= shadow_arr;
                even_frame <= !even_frame;
            end
            if (skip_inc && skip_count != 8'hFF) skip_count <= skip_count + 8'd1;
            slot_err <= accept && !slot_ok;
        end
    end

    assign entity_1      = active[0];
    assign entity_2      = active[1];
    assign entity_3      = active[2];
    assign entity_4      = active[3];
    assign entity_5      = active[4];
    assign entity_6      = active[5];
    assign entity_8_flip = active[6];
    assign entity_9_flip = active[7];
    assign entity_7      = active_arr;
endmodule
